// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that time-shares one bank of WIDTH SR flip-flops between NREQ requesters.
// Optional build macro SR_ARB_ERR_STICKY_EN: sticky err plus per-requester err_src record.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] cmd_s,
  input  logic [NREQ*WIDTH-1:0] cmd_r,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      s_out,
  output logic [WIDTH-1:0]      r_out,
  output logic [WIDTH-1:0]      q_mirror,
  output logic                  busy,
  output logic                  err
`ifdef SR_ARB_ERR_STICKY_EN
  ,
  output logic [NREQ-1:0]       err_src
`endif
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, APPLY} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    nxt_ptr;
  logic [PW-1:0]    sel_idle;
  logic [PW-1:0]    sel_apply;
  logic [PW-1:0]    sel;
  logic [NREQ-1:0]  req_apply;
  logic             load;
  logic [WIDTH-1:0] s_sel;
  logic [WIDTH-1:0] r_sel;
  logic [WIDTH-1:0] s_lat;
  logic [WIDTH-1:0] r_lat;
  logic [WIDTH-1:0] ill;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] o;
    o = '0;
    for (int k = 0; k < NREQ; k++)
      if (i == PW'(k)) o[k] = 1'b1;
    return o;
  endfunction

  // First set bit of r at or above p, wrapping; scanned downward so the nearest one wins.
  function automatic logic [PW-1:0] pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    int            idx;
    w = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (r[idx[PW-1:0]]) w = idx[PW-1:0];
    end
    return w;
  endfunction

  always_comb begin
    nxt_ptr   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    // The requester just granted may still be dropping req; keep it out of this selection.
    req_apply = req & ~onehot(win);
    sel_idle  = pick(req, ptr);
    sel_apply = pick(req_apply, nxt_ptr);
    load      = ((state == IDLE) && (|req)) || ((state == APPLY) && (|req_apply));
    sel       = (state == APPLY) ? sel_apply : sel_idle;
    s_sel     = '0;
    r_sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) begin
        s_sel = cmd_s[i*WIDTH +: WIDTH];
        r_sel = cmd_r[i*WIDTH +: WIDTH];
      end
    end
    ill = s_lat & r_lat;
  end

  // Selection stage: command masks of the winner captured alongside the grant
  always_ff @(posedge clk) begin
    if (load) begin
      s_lat <= s_sel;
      r_lat <= r_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      gnt      <= '0;
      s_out    <= '0;
      r_out    <= '0;
      q_mirror <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef SR_ARB_ERR_STICKY_EN
      err_src  <= '0;
`endif
    end else begin
      gnt   <= '0;
      s_out <= '0;
      r_out <= '0;
`ifndef SR_ARB_ERR_STICKY_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= sel_idle;
            gnt   <= onehot(sel_idle);
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        // Grant stage: illegal s=r=1 bits are dropped from both pulses
        GRANT: begin
          s_out <= s_lat & ~ill;
          r_out <= r_lat & ~ill;
`ifdef SR_ARB_ERR_STICKY_EN
          if (|ill) begin
            err     <= 1'b1;
            err_src <= err_src | onehot(win);
          end
`else
          err   <= |ill;
`endif
          state <= APPLY;
        end
        // Apply stage: mirror follows the pulse, next winner chosen from the advanced pointer
        APPLY: begin
          q_mirror <= (q_mirror & ~r_out) | s_out;
          ptr      <= nxt_ptr;
          if (|req_apply) begin
            win   <= sel_apply;
            gnt   <= onehot(sel_apply);
            state <= GRANT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench for sr_bank_arbiter: table-driven single transactions, scoreboard of expected
// grants/pulses/mirror values, plus hand-written fairness, wrap, slow-drop and reset sequences.
module tb_sr_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] cmd_s = '0;
  logic [NREQ*WIDTH-1:0] cmd_r = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      s_out;
  logic [WIDTH-1:0]      r_out;
  logic [WIDTH-1:0]      q_mirror;
  logic                  busy;
  logic                  err;
`ifdef SR_ARB_ERR_STICKY_EN
  logic [NREQ-1:0]       err_src;
`endif

  sr_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .cmd_s    (cmd_s),
    .cmd_r    (cmd_r),
    .gnt      (gnt),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_mirror (q_mirror),
    .busy     (busy),
    .err      (err)
`ifdef SR_ARB_ERR_STICKY_EN
    ,
    .err_src  (err_src)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int             cyc;
    logic [NREQ-1:0] gnt;
    logic [7:0]     s;
    logic [7:0]     r;
    logic [7:0]     q;
    logic           err;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int c, input int id, input logic [7:0] s, input logic [7:0] r,
                      input logic [7:0] q, input logic e);
    exp_t x;
    x.cyc = c;
    x.gnt = 4'(1 << id);
    x.s   = s;
    x.r   = r;
    x.q   = q;
    x.err = e;
    sb.push_back(x);
  endtask

  // Monitor: grant -> pulses one cycle later -> mirror one cycle after that
  exp_t c1, c2;
  bit   ph1 = 1'b0;
  bit   ph2 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ph1 = 1'b0;
      ph2 = 1'b0;
    end else begin
      if (ph2) begin
        chk("q_mirror", q_mirror, c2.q);
        ph2 = 1'b0;
      end
      if (ph1) begin
        chk("s_out", s_out, c1.s);
        chk("r_out", r_out, c1.r);
`ifdef SR_ARB_ERR_STICKY_EN
        if (c1.err) chk("err", err, 1);
`else
        chk("err", err, c1.err);
`endif
        c2  = c1;
        ph2 = 1'b1;
        ph1 = 1'b0;
      end else begin
        chk("idle_s_out", s_out, 0);
        chk("idle_r_out", r_out, 0);
`ifndef SR_ARB_ERR_STICKY_EN
        chk("idle_err", err, 0);
`endif
      end
      if (gnt !== '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gnt: got %h expected 0 (cycle %0d)", gnt, cyc);
        end else begin
          c1 = sb.pop_front();
          chk("gnt", gnt, c1.gnt);
          chk("gnt_cycle", cyc, c1.cyc);
          ph1 = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] cs;
    logic [7:0] cr;
    logic [7:0] es;
    logic [7:0] er;
    logic [7:0] eq;
    logic       ee;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int k;
    int t;
    tbl[0] = '{2, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F, 1'b0};
    tbl[1] = '{1, 8'h81, 8'h01, 8'h80, 8'h00, 8'h8F, 1'b1};
    tbl[2] = '{0, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'h80, 1'b0};
    tbl[3] = '{3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 1'b0};
    tbl[4] = '{3, 8'h3C, 8'hC3, 8'h3C, 8'hC3, 8'h3C, 1'b0};
    tbl[5] = '{1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3C, 1'b1};
    tbl[6] = '{0, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 1'b0};

    // Reset held with every requester asking
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", gnt, 0);
      chk("rst_s_out", s_out, 0);
      chk("rst_r_out", r_out, 0);
      chk("rst_q_mirror", q_mirror, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
    end
    rst_n = 1'b1;
    req   = '0;
    step();
    chk("idle_busy", busy, 0);

    // Table: isolated transactions from IDLE
    foreach (tbl[i]) begin
      cmd_s = '0;
      cmd_r = '0;
      cmd_s[tbl[i].id*WIDTH +: WIDTH] = tbl[i].cs;
      cmd_r[tbl[i].id*WIDTH +: WIDTH] = tbl[i].cr;
      req = 4'(1 << tbl[i].id);
      push(cyc + 1, tbl[i].id, tbl[i].es, tbl[i].er, tbl[i].eq, tbl[i].ee);
      step();
      chk("busy_grant", busy, 1);
      req = '0;
      step();
      chk("busy_apply", busy, 1);
      step();
      chk("busy_done", busy, 0);
    end
`ifdef SR_ARB_ERR_STICKY_EN
    chk("err_sticky", err, 1);
    chk("err_src", err_src, 4'b0010);
`endif

    // Reset asserted during APPLY drops the pending pulse and clears the mirror
    cmd_s = '0;
    cmd_r = '0;
    cmd_s[1*WIDTH +: WIDTH] = 8'hF0;
    req = 4'b0010;
    push(cyc + 1, 1, 8'hF0, 8'h00, 8'hF5, 1'b0);
    step();
    req = '0;
    step();
    rst_n = 1'b0;
    step();
    chk("rsta_s_out", s_out, 0);
    chk("rsta_r_out", r_out, 0);
    chk("rsta_q_mirror", q_mirror, 0);
    chk("rsta_busy", busy, 0);
    chk("rsta_gnt", gnt, 0);
    chk("rsta_err", err, 0);
    rst_n = 1'b1;

    // Fairness with all requesting; first grant to 0 also shows ptr was cleared
    cmd_s = 32'h08040201;
    cmd_r = '0;
    req   = 4'b1111;
    k     = cyc;
    push(k + 1, 0, 8'h01, 8'h00, 8'h01, 1'b0);
    push(k + 3, 1, 8'h02, 8'h00, 8'h03, 1'b0);
    push(k + 5, 2, 8'h04, 8'h00, 8'h07, 1'b0);
    push(k + 7, 3, 8'h08, 8'h00, 8'h0F, 1'b0);
    push(k + 9, 0, 8'h01, 8'h00, 8'h0F, 1'b0);
    repeat (9) step();
    req = '0;
    repeat (3) step();

    // Wrap-around: grant 3, requester 3 slow to drop while 0 asks -> 0 next
    cmd_s = 32'h00000001;
    cmd_r = 32'h0F000000;
    req   = 4'b1000;
    k     = cyc;
    push(k + 1, 3, 8'h00, 8'h0F, 8'h00, 1'b0);
    push(k + 3, 0, 8'h01, 8'h00, 8'h01, 1'b0);
    step();
    req = 4'b1001;
    step();
    step();
    req = '0;
    repeat (3) step();

    // Slow drop alone must not be granted twice
    cmd_s = '0;
    cmd_r = 32'h00010000;
    req   = 4'b0100;
    push(cyc + 1, 2, 8'h00, 8'h01, 8'h00, 1'b0);
    repeat (3) step();
    req = '0;
    repeat (4) step();
    chk("final_busy", busy, 0);

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      step();
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
